// File: rtl/tt_um_seq_adder_team11.sv
// rtl/tt_um_seq_adder_team11.sv - byte-serial WIDTH-bit add/sub/load accumulator on the TinyTapeout pin set
// Optional build macro TEAM11_ADDER_SAT_EN: saturate ADD overflow to all ones and SUB underflow to zero.
module tt_um_seq_adder_team11 #(
   parameter int WIDTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int NBYTES = WIDTH / 8;
   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_SUB   = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

`ifdef TEAM11_ADDER_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, COLLECT, EXEC, DONE} state_t;

   state_t state, state_next;

   logic [NBYTES-1:0][7:0] acc, operand, acc_final;
   logic [1:0]             op;
   logic [CW-1:0]          cnt, cnt_next, rd_ptr, rd_next;
   logic                   carry, c_flag, z_flag, c_final, busy;
   logic [7:0]             addend;
   logic [8:0]             sum;

   logic start, byte_valid, rd_adv;
   logic [1:0] op_in;
   logic unused_bits;

   assign start       = uio_in[0];
   assign op_in       = uio_in[2:1];
   assign byte_valid  = uio_in[3];
   assign rd_adv      = uio_in[4];
   assign unused_bits = &uio_in[7:5];

   // Explicit wrap keeps the counters correct for non-power-of-two byte counts.
   assign cnt_next = (cnt == LAST) ? '0 : cnt + 1'b1;
   assign rd_next  = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;

   assign addend = (op == OP_SUB) ? ~operand[cnt] : operand[cnt];
   assign sum    = {1'b0, acc[cnt]} + {1'b0, addend} + {8'b0, carry};

   always_comb begin
      acc_final = acc;
      c_final   = 1'b0;
      case (op)
         OP_CLEAR: acc_final = '0;
         OP_ADD: begin
            c_final = carry;
            if (SAT_EN && carry) acc_final = '1;
         end
         OP_SUB: begin
            c_final = ~carry;
            if (SAT_EN && !carry) acc_final = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else if (ena)
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = (op_in == OP_CLEAR) ? DONE : COLLECT;
         COLLECT: if (byte_valid && cnt == LAST) state_next = EXEC;
         EXEC:    if (cnt == LAST) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc     <= '0;
         operand <= '0;
         op      <= OP_LOAD;
         carry   <= 1'b0;
         c_flag  <= 1'b0;
         z_flag  <= 1'b1;
         rd_ptr  <= '0;
         cnt     <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (start) begin
                  op  <= op_in;
                  cnt <= '0;
               end else if (rd_adv) begin
                  rd_ptr <= rd_next;
               end
            end
            COLLECT: begin
               if (byte_valid) begin
                  operand[cnt] <= ui_in;
                  cnt          <= cnt_next;
                  // SUB is computed as acc + ~operand + 1, so the first carry-in is 1.
                  if (cnt == LAST) carry <= (op == OP_SUB);
               end
            end
            EXEC: begin
               acc[cnt] <= (op == OP_LOAD) ? operand[cnt] : sum[7:0];
               carry    <= sum[8];
               cnt      <= cnt_next;
            end
            DONE: begin
               acc    <= acc_final;
               c_flag <= c_final;
               z_flag <= (acc_final == '0);
               rd_ptr <= '0;
            end
            default: ;
         endcase
      end
   end

   assign uo_out  = acc[rd_ptr];
   assign uio_out = {busy, c_flag, z_flag, 5'b0};
   assign uio_oe  = 8'hE0;

endmodule

// File: tb/tb_tt_um_seq_adder_team11.sv
// tb/tb_tt_um_seq_adder_team11.sv - randomized self-checking bench for tt_um_seq_adder_team11
module tb_tt_um_seq_adder_team11;

   localparam int W  = 16;
   localparam int NB = W / 8;
   localparam longint unsigned MASK = (64'd1 << W) - 1;

`ifdef TEAM11_ADDER_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b1;
   logic [7:0] ui_in = 8'h00;
   logic start = 1'b0, bv = 1'b0, rd_adv = 1'b0;
   logic [1:0] op = 2'b00;
   logic [2:0] junk = 3'b000;
   logic [7:0] uio_in;
   logic [7:0] uo_out, uio_out, uio_oe;

   assign uio_in = {junk, rd_adv, bv, op, start};

   tt_um_seq_adder_team11 #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
      .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   longint unsigned m_acc = 0;
   bit m_c = 1'b0, m_z = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model(input logic [1:0] o, input longint unsigned v);
      longint unsigned full;
      case (o)
         2'd0: begin m_acc = v; m_c = 0; end
         2'd1: begin
            full  = m_acc + v;
            m_c   = (full > MASK);
            m_acc = full & MASK;
            if (SAT && m_c) m_acc = MASK;
         end
         2'd2: begin
            m_c   = (v > m_acc);
            m_acc = (m_acc - v) & MASK;
            if (SAT && m_c) m_acc = 0;
         end
         default: begin m_acc = 0; m_c = 0; end
      endcase
      m_z = (m_acc == 0);
   endtask

   // Called at a negedge with rd_ptr at 0; walks every byte and checks the wrap back to byte 0.
   task automatic read_check(input string tag);
      logic [63:0] a;
      a = m_acc;
      for (int i = 0; i <= NB; i++) begin
         check($sformatf("%s_byte%0d", tag, i), {24'b0, uo_out}, {24'b0, a[8*(i%NB) +: 8]});
         if (i < NB) begin
            rd_adv = 1'b1;
            @(negedge clk);
            rd_adv = 1'b0;
         end
      end
   endtask

   task automatic do_op(input string tag, input logic [1:0] o, input logic [W-1:0] v);
      int cycles;
      int lat;
      @(negedge clk);
      start = 1'b1; op = o; rd_adv = 1'($urandom); junk = 3'($urandom);
      @(negedge clk);
      start = 1'b0; rd_adv = 1'b0; op = 2'($urandom);
      if (o != 2'd3) begin
         for (int i = 0; i < NB; i++) begin
            repeat ($urandom_range(0, 3)) begin
               if ($urandom_range(0, 1) == 1) begin
                  ena = 1'b0; bv = 1'($urandom);
               end else begin
                  bv = 1'b0;
               end
               ui_in = 8'($urandom); start = 1'($urandom); rd_adv = 1'($urandom);
               @(negedge clk);
               ena = 1'b1;
            end
            bv = 1'b1; ui_in = v[8*i +: 8]; start = 1'($urandom); rd_adv = 1'($urandom);
            @(negedge clk);
            bv = 1'b0; start = 1'b0; rd_adv = 1'b0; ui_in = 8'($urandom);
         end
         lat = NB + 1;
      end else begin
         lat = 1;
      end
      cycles = 0;
      while (uio_out[7] && cycles < 20) begin
         start = 1'($urandom); op = 2'($urandom); rd_adv = 1'($urandom);
         @(negedge clk);
         cycles++;
      end
      start = 1'b0; rd_adv = 1'b0;
      check({tag, "_latency"}, cycles, lat);
      model(o, 64'(v));
      check({tag, "_C"}, {31'b0, uio_out[6]}, {31'b0, m_c});
      check({tag, "_Z"}, {31'b0, uio_out[5]}, {31'b0, m_z});
      read_check(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rst_busy", {31'b0, uio_out[7]}, 32'd0);
      check("rst_flags", {24'b0, uio_out}, 32'h20);
      check("rst_uo", {24'b0, uo_out}, 32'h0);
      check("rst_oe", {24'b0, uio_oe}, 32'hE0);

      do_op("load", 2'd0, 16'h1234);
      do_op("add", 2'd1, 16'hF00F);
      do_op("sub", 2'd2, 16'h0244);
      do_op("clear", 2'd3, 16'h0000);
      do_op("load1", 2'd0, 16'h0001);
      do_op("addmax", 2'd1, 16'hFFFF);
      do_op("sub0", 2'd2, 16'h0000);

      // rd_adv while disabled must not move the read pointer
      do_op("load2", 2'd0, 16'hA55A);
      ena = 1'b0; rd_adv = 1'b1;
      repeat (3) @(negedge clk);
      ena = 1'b1; rd_adv = 1'b0;
      check("ena_freeze_uo", {24'b0, uo_out}, 32'h5A);

      for (int n = 0; n < 40; n++) begin
         logic [1:0] ro;
         logic [W-1:0] rv;
         ro = 2'($urandom);
         rv = ($urandom_range(0, 3) == 0) ? W'(MASK - m_acc) : W'($urandom);
         do_op($sformatf("rnd%0d", n), ro, rv);
      end

      // reset in the middle of EXEC
      @(negedge clk);
      start = 1'b1; op = 2'd1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < NB; i++) begin
         bv = 1'b1; ui_in = 8'h77;
         @(negedge clk);
      end
      bv = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_acc = 0; m_c = 0; m_z = 1;
      check("mid_rst_busy", {31'b0, uio_out[7]}, 32'd0);
      check("mid_rst_flags", {24'b0, uio_out}, 32'h20);
      check("mid_rst_oe", {24'b0, uio_oe}, 32'hE0);
      read_check("mid_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
